mul_add_seq: RTL

- Sequential unsigned multiplier built by repeated addition: the additive counterpart to the repeated-subtraction GCD datapath.
- Latches two W-bit operands on a start handshake, accumulates operand a into a 2W-bit register b times, then pulses done with the product held.
- Sits beside the GCD unit and feeds the LCM path: lcm = (x*y)/gcd.

---
 rtl/mul_pkg.sv | 10 +
 rtl/mul_add_seq_if.sv | 12 +
 rtl/add_2w.sv | 8 +
 rtl/mul_add_seq.sv | 89 ++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared multiplier/LCM package: FSM state encoding and default operand width.
package mul_pkg;
    localparam int WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mul_add_seq_if.sv
// Request/response bundle for the repeated-addition multiplier.
interface mul_add_seq_if #(parameter int WIDTH = mul_pkg::WIDTH);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/add_2w.sv
// Combinational 2*WIDTH-bit unsigned adder, the additive twin of the GCD SUB block.
module add_2w #(parameter int WIDTH = 4) (
    input  logic [2*WIDTH-1:0] x,
    input  logic [2*WIDTH-1:0] y,
    output logic [2*WIDTH-1:0] sum
);
    assign sum = x + y;
endmodule

// File: rtl/mul_add_seq.sv
// Sequential unsigned multiplier by repeated addition; feeds the LCM path.
// Optional MUL_SWAP_MIN_EN: iterate over min(a,b) instead of b.
module mul_add_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_add_seq_if.slave bus
);
    state_t               state, state_n;
    logic [2*WIDTH-1:0]   acc, acc_n, sum;
    logic [WIDTH-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]     a_r, a_r_n;
    logic [2*WIDTH-1:0]   product, product_n;
    logic                 busy_q, done_q;

    add_2w #(.WIDTH(WIDTH)) u_add (
        .x   (acc),
        .y   ({{WIDTH{1'b0}}, a_r}),
        .sum (sum)
    );

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        cnt_n     = cnt;
        a_r_n     = a_r;
        product_n = product;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef MUL_SWAP_MIN_EN
                    // Fewer iterations when the smaller operand drives the count.
                    if (bus.b > bus.a) begin
                        a_r_n = bus.b;
                        cnt_n = bus.a;
                    end else begin
                        a_r_n = bus.a;
                        cnt_n = bus.b;
                    end
`else
                    a_r_n = bus.a;
                    cnt_n = bus.b;
`endif
                    acc_n   = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (cnt != '0) begin
                    acc_n = sum;
                    cnt_n = cnt - WIDTH'(1);
                end else begin
                    product_n = acc;
                    state_n   = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // busy/done come from flops driven by next state, so no input-to-output path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            a_r     <= '0;
            product <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            a_r     <= a_r_n;
            product <= product_n;
            busy_q  <= (state_n != IDLE);
            done_q  <= (state_n == DONE);
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product;
endmodule
